accel_ram_responder: RTL

- Memory-side responder for the shared accelerator RAM port; it sits downstream of the CPU/FFT/Crypto memory arbiter.
- Accepts single-cycle valid/write/addr/wdata requests and commits writes to an internal synchronous word array.
- Returns read data after a fixed, parameterised latency, with a data-valid strobe.
- Provides a hardware zero-fill engine, out-of-range error reporting, and saturating access statistics.

---
 rtl/accel_mem_pkg.sv | 14 +
 rtl/accel_ram_responder_if.sv | 28 ++
 rtl/accel_ram_rd_pipe.sv | 59 +++++
 rtl/accel_ram_responder.sv | 139 +++++++++++++
 4 files changed

// File: rtl/accel_mem_pkg.sv
// Shared constants and state encoding for the accelerator RAM port.
// Imported by the arbiter-side masters and by the responder.
package accel_mem_pkg;

  localparam int ACC_DATA_W = 19;
  localparam int ACC_ADDR_W = 19;
  localparam int ACC_CNT_W  = 16;

  typedef enum logic [0:0] {
    ACC_IDLE = 1'b0,
    ACC_INIT = 1'b1
  } acc_state_e;

endpackage

// File: rtl/accel_ram_responder_if.sv
// Request/response bundle between the memory arbiter and the RAM responder.
// The arbiter side drives requests; the responder drives read results and errors.
interface accel_ram_responder_if
  import accel_mem_pkg::*;
#(
  parameter int DATA_W = ACC_DATA_W,
  parameter int ADDR_W = ACC_ADDR_W
);

  logic              ram_valid;
  logic              ram_write;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic              rdata_valid;
  logic              err_oob;

  modport master (
    output ram_valid, ram_write, ram_addr, ram_wdata,
    input  ram_rdata, rdata_valid, err_oob
  );

  modport slave (
    input  ram_valid, ram_write, ram_addr, ram_wdata,
    output ram_rdata, rdata_valid, err_oob
  );

endinterface

// File: rtl/accel_ram_rd_pipe.sv
// Fixed-latency read return pipeline carrying {valid, oob, data}.
// The final stage keeps its data between results so the read bus holds its last value.
module accel_ram_rd_pipe #(
  parameter int DATA_W = 19,
  parameter int LAT    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid_i,
  input  logic              in_oob_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              nxt_oob_o,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] out_data_o
);

  logic [LAT-1:0]    vld_q;
  logic [LAT-1:0]    vld_d;
  logic [LAT-1:0]    oob_q;
  logic [LAT-1:0]    oob_d;
  logic [DATA_W-1:0] dat_q [LAT];
  logic [DATA_W-1:0] dat_d [LAT];

  always_comb begin
    vld_d    = '0;
    oob_d    = '0;
    vld_d[0] = in_valid_i;
    oob_d[0] = in_valid_i & in_oob_i;
    dat_d[0] = in_data_i;
    for (int i = 1; i < LAT; i++) begin
      vld_d[i] = vld_q[i-1];
      oob_d[i] = oob_q[i-1];
      dat_d[i] = dat_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q <= '0;
      oob_q <= '0;
      for (int i = 0; i < LAT; i++) begin
        dat_q[i] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      oob_q <= oob_d;
      for (int i = 0; i < LAT; i++) begin
        if ((i != LAT - 1) || vld_d[i]) begin
          dat_q[i] <= dat_d[i];
        end
      end
    end
  end

  assign nxt_oob_o   = oob_d[LAT-1];
  assign out_valid_o = vld_q[LAT-1];
  assign out_data_o  = dat_q[LAT-1];

endmodule

// File: rtl/accel_ram_responder.sv
// Memory-side responder for the shared accelerator RAM port: synchronous word
// array, fixed-latency reads, zero-fill engine, error flags and access statistics.
module accel_ram_responder
  import accel_mem_pkg::*;
#(
  parameter int DATA_W     = ACC_DATA_W,
  parameter int ADDR_W     = ACC_ADDR_W,
  parameter int DEPTH_LOG2 = 12,
  parameter int RD_LAT     = 2,
  parameter int CNT_W      = ACC_CNT_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  accel_ram_responder_if.slave  bus,
  input  logic                  init_start,
  output logic                  busy,
  input  logic                  clr_stats,
  output logic                  err_sticky,
  output logic [CNT_W-1:0]      rd_count,
  output logic [CNT_W-1:0]      wr_count
);

  localparam int         WORDS  = 2 ** DEPTH_LOG2;
  localparam logic [0:0] S_IDLE = 1'(ACC_IDLE);
  localparam logic [0:0] S_INIT = 1'(ACC_INIT);

  logic [DATA_W-1:0]     mem_q [WORDS];
  logic [0:0]            state_q, state_d;
  logic [DEPTH_LOG2-1:0] ptr_q, ptr_d;
  logic                  busy_q, err_oob_q, err_sticky_q;
  logic [CNT_W-1:0]      rd_cnt_q, wr_cnt_q;

  logic                  accept_s, oob_s, wr_ok_s, wr_oob_s, rd_ok_s, rd_issue_s, err_set_s;
  logic [DEPTH_LOG2-1:0] idx_s;
  logic [DATA_W-1:0]     rd_word_s;
  logic                  pipe_nxt_oob_s;

  assign accept_s   = bus.ram_valid & (state_q == S_IDLE);
  assign oob_s      = |bus.ram_addr[ADDR_W-1:DEPTH_LOG2];
  assign idx_s      = bus.ram_addr[DEPTH_LOG2-1:0];
  assign wr_ok_s    = accept_s & bus.ram_write & ~oob_s;
  assign wr_oob_s   = accept_s & bus.ram_write & oob_s;
  assign rd_issue_s = accept_s & ~bus.ram_write;
  assign rd_ok_s    = rd_issue_s & ~oob_s;
  // Requests arriving while the fill engine owns the array are dropped but flagged.
  assign err_set_s  = (accept_s & oob_s) | (bus.ram_valid & (state_q == S_INIT));
  assign rd_word_s  = oob_s ? '0 : mem_q[idx_s];

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      S_IDLE: begin
        if (init_start) begin
          state_d = S_INIT;
          ptr_d   = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_INIT: begin
        ptr_d = ptr_q + DEPTH_LOG2'(1);
        if (ptr_q == {DEPTH_LOG2{1'b1}}) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_INIT;
        end
      end
      default: begin
        state_d = S_IDLE;
        ptr_d   = '0;
      end
    endcase
  end

  // Array contents survive reset; only the fill engine or accepted writes change them.
  always_ff @(posedge clk) begin
    if (state_q == S_INIT) begin
      mem_q[ptr_q] <= '0;
    end else if (wr_ok_s) begin
      mem_q[idx_s] <= bus.ram_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      busy_q       <= 1'b0;
      err_oob_q    <= 1'b0;
      err_sticky_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      busy_q    <= (state_d == S_INIT);
      err_oob_q <= pipe_nxt_oob_s | wr_oob_s;
      if (err_set_s) begin
        err_sticky_q <= 1'b1;
      end else if (clr_stats) begin
        err_sticky_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr_stats) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      if (rd_ok_s && (rd_cnt_q != {CNT_W{1'b1}})) begin
        rd_cnt_q <= rd_cnt_q + CNT_W'(1);
      end
      if (wr_ok_s && (wr_cnt_q != {CNT_W{1'b1}})) begin
        wr_cnt_q <= wr_cnt_q + CNT_W'(1);
      end
    end
  end

  accel_ram_rd_pipe #(
    .DATA_W (DATA_W),
    .LAT    (RD_LAT)
  ) u_rd_pipe (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (rd_issue_s),
    .in_oob_i    (oob_s),
    .in_data_i   (rd_word_s),
    .nxt_oob_o   (pipe_nxt_oob_s),
    .out_valid_o (bus.rdata_valid),
    .out_data_o  (bus.ram_rdata)
  );

  assign bus.err_oob = err_oob_q;
  assign busy        = busy_q;
  assign err_sticky  = err_sticky_q;
  assign rd_count    = rd_cnt_q;
  assign wr_count    = wr_cnt_q;

endmodule
